// File: rtl/dm_mc.sv
// Multi-cycle data memory: holds the MEM stage with a combinational stall for LAT+1 cycles,
// then pulses done for one cycle with registered read data.
module dm_mc #(
   parameter int AW  = 10,
   parameter int LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic        re,
   input  logic        we,
   input  logic [15:0] wrt_data,
   output logic [15:0] rd_data,
   output logic        stall,
   output logic        done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic [AW-1:0] addr_l;
   logic [15:0]   wdata_l;
   logic          op_wr;
   logic          access;
   logic [15:0]   mem [2**AW];

   // Upper address bits alias onto the decoded range.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[15:AW];

   assign access = (state == BUSY) && (cnt == 4'd0);

   always_comb begin
      stall = 1'b0;
      if (state == BUSY)
         stall = 1'b1;
      else if (state == IDLE)
         stall = re | we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_l  <= '0;
         wdata_l <= 16'h0000;
         op_wr   <= 1'b0;
         rd_data <= 16'h0000;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (re | we) begin
                  addr_l  <= addr[AW-1:0];
                  wdata_l <= wrt_data;
                  op_wr   <= we;
                  cnt     <= CNT_INIT;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (!op_wr)
                     rd_data <= mem[addr_l];
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            // The request is still held by the pipeline here; it must not retrigger.
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // No reset on the array; an async reset in BUSY drops state to IDLE, so access is never seen.
   always_ff @(posedge clk) begin
      if (access && op_wr)
         mem[addr_l] <= wdata_l;
   end

endmodule

// File: doc/dm_mc.md
Name: dm_mc

Overview:
- Multi-cycle data-memory responder that sits behind the MEM pipeline stage and answers its read/write strobes.
- Replaces the single-cycle data memory, so the core can model realistic memory latency.
- Holds off the pipeline with a combinational `stall` for a programmable number of cycles.
- Performs the access, then presents registered read data for one completion cycle.

Parameters:
- AW, 10, word-address bits actually decoded; memory depth is 2^AW 16-bit words.
- LAT, 3, access latency in cycles spent in BUSY; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  16  word address from the MEM pipeline register; only addr[AW-1:0] is used.
- re  input  1  read request (MemRead).
- we  input  1  write request (MemWrite).
- wrt_data  input  16  write data.
- rd_data  output  16  registered read data.
- stall  output  1  high while a request is pending or in progress.
- done  output  1  one-cycle pulse in the completion cycle.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, rd_data=16'h0000, done=0, stall=0; latched addr/data/op are cleared.
  - Memory array contents are NOT cleared.
  - Reset mid-BUSY aborts the access: no array write occurs and rd_data is not updated.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = re | we (combinational).
  - On posedge with re|we=1: latch addr[AW-1:0], wrt_data, and op. op=WRITE if we=1, else READ; we has priority when both are high.
  - Same edge: cnt<=LAT-1, go to BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - stall=1 regardless of inputs; input changes are ignored because latched values are used.
  - Each posedge: if cnt!=0 then cnt<=cnt-1.
  - If cnt==0, perform the access on that edge and go to DONE.
    - WRITE: mem[addr_l]<=wdata_l; rd_data is unchanged.
    - READ: rd_data<=mem[addr_l].
- DONE:
  - stall=0, done=1 for exactly one cycle; the pipeline advances at the end of this cycle.
  - re/we are still the old request during DONE and MUST be ignored.
  - Next state is always IDLE.
- Latency:
  - With a request presented in cycle 0, stall is high for cycles 0..LAT (LAT+1 cycles).
  - DONE is in cycle LAT+1; rd_data is valid from cycle LAT+1 and holds until the next read completes.
- Back-to-back requests:
  - A new request appears in the cycle after DONE (IDLE), and stall rises immediately, combinationally.
  - Throughput is one access per LAT+2 cycles.
- Idle behaviour: with no request, rd_data holds its value and done=0.
- Address wrap: addr bits above AW-1 are ignored, e.g. with AW=10, 16'h0400 aliases to 16'h0000.
- Timing paths: stall is the only combinational input-to-output path; rd_data and done are registered.

Test Plan:
- Reset mid-request: rst pulse during BUSY -> within the same cycle rd_data=0, stall=0, done=0, state IDLE; a later read of that address returns the pre-reset contents (write aborted).
- Write then read (LAT=3): write addr=16'h0005 data=16'hBEEF at cycle 0 -> stall high cycles 0–3, done=1 in cycle 4, rd_data unchanged. Read addr=16'h0005 at cycle 5 -> stall high cycles 5–8, done in cycle 9, rd_data=16'hBEEF from cycle 9.
- Simultaneous re=we=1: addr=16'h0010 data=16'h1234 -> write performed, rd_data keeps its prior value. A following read of 16'h0010 returns 16'h1234.
- Inputs change during BUSY: request a read of 16'h0005, then drive addr=16'h0006 and we=1 while BUSY -> the read of 16'h0005 completes and no write to 16'h0006 occurs.
- DONE ignores held request: keep re=1 and addr constant through DONE -> exactly one done pulse, then a new access starts in the next IDLE cycle (stall rises there).
- Aliasing and LAT=1: with LAT=1, write 16'h0400 data=16'hA5A5 -> stall high 2 cycles; a read of 16'h0000 returns 16'hA5A5.
